// File: rtl/priority_encoder_pkg.sv
// Shared constants and elaboration helpers for the segmented priority encoder.
package priority_encoder_pkg;

  localparam int PE_WIDTH_DEF = 16;
  localparam int PE_SEG_W_DEF = 4;

  // Index width for n positions; never below 1 so single-bit ranges stay legal.
  function automatic int clog2_f(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_seg_find.sv
// Local search within one segment: nz flag, one-hot highest/lowest set bit (+ local index with PRIO_ENC_IDX_EN).
// Latency: combinational.
// Backpressure: none, pure function of seg.
module pe_seg_find
  import priority_encoder_pkg::*;
#(
  parameter int SEG_W = PE_SEG_W_DEF
) (
  input  logic [SEG_W-1:0] seg,
  output logic             nz,
  output logic [SEG_W-1:0] left,
  output logic [SEG_W-1:0] right
`ifdef PRIO_ENC_IDX_EN
  ,
  output logic [clog2_f(SEG_W)-1:0] left_idx,
  output logic [clog2_f(SEG_W)-1:0] right_idx
`endif
);

`ifdef PRIO_ENC_IDX_EN
  localparam int SIW = clog2_f(SEG_W);
`endif

  assign nz = |seg;

  // Ascending scan keeps the highest set bit, descending scan keeps the lowest.
  always_comb begin
    left  = '0;
    right = '0;
`ifdef PRIO_ENC_IDX_EN
    left_idx  = '0;
    right_idx = '0;
`endif
    for (int i = 0; i < SEG_W; i++) begin
      if (seg[i]) begin
        left    = '0;
        left[i] = 1'b1;
`ifdef PRIO_ENC_IDX_EN
        left_idx = SIW'(i);
`endif
      end
    end
    for (int i = SEG_W - 1; i >= 0; i--) begin
      if (seg[i]) begin
        right    = '0;
        right[i] = 1'b1;
`ifdef PRIO_ENC_IDX_EN
        right_idx = SIW'(i);
`endif
      end
    end
  end

endmodule

// File: rtl/priority_encoder_pipe.sv
// Two-stage segmented priority encoder: one-hot MSB/LSB + zero flag; indices too when PRIO_ENC_IDX_EN is defined.
// Latency: 2 register stages, 1 word/cycle sustained.
// Backpressure: valid/ready; a stage loads when empty or draining, data_rdy_o low only with both stages full and data_rdy_i low.
module priority_encoder_pipe
  import priority_encoder_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH_DEF,
  parameter int SEG_W = PE_SEG_W_DEF
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic             data_rdy_o,
  output logic [WIDTH-1:0] data_left_o,
  output logic [WIDTH-1:0] data_right_o,
  output logic             data_zero_o,
  output logic             data_val_o,
  input  logic             data_rdy_i
`ifdef PRIO_ENC_IDX_EN
  ,
  output logic [clog2_f(WIDTH)-1:0] data_left_idx_o,
  output logic [clog2_f(WIDTH)-1:0] data_right_idx_o
`endif
);

  localparam int NSEG = WIDTH / SEG_W;

  if (((WIDTH % SEG_W) != 0) || (NSEG < 2)) begin : g_param_chk
    $error("priority_encoder_pipe: WIDTH must be a multiple of SEG_W with at least 2 segments");
  end

  typedef struct packed {
    logic [NSEG-1:0]  nz;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
  } s1_t;

  logic [NSEG-1:0]  seg_nz;
  logic [WIDTH-1:0] seg_left;
  logic [WIDTH-1:0] seg_right;

`ifdef PRIO_ENC_IDX_EN
  localparam int IW  = clog2_f(WIDTH);
  localparam int SIW = clog2_f(SEG_W);
  logic [NSEG*SIW-1:0] seg_lidx, seg_ridx;
  logic [NSEG*SIW-1:0] s1_lidx, s1_ridx;
  logic [IW-1:0]       left_idx_n, right_idx_n;
`endif

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    pe_seg_find #(.SEG_W(SEG_W)) u_find (
      .seg       (data_i[k*SEG_W +: SEG_W]),
      .nz        (seg_nz[k]),
      .left      (seg_left[k*SEG_W +: SEG_W]),
      .right     (seg_right[k*SEG_W +: SEG_W])
`ifdef PRIO_ENC_IDX_EN
      ,
      .left_idx  (seg_lidx[k*SIW +: SIW]),
      .right_idx (seg_ridx[k*SIW +: SIW])
`endif
    );
  end

  s1_t  s1_q;
  logic s1_vld;
  logic rdy2;

  assign rdy2       = ~data_val_o | data_rdy_i;
  assign data_rdy_o = ~s1_vld | rdy2;

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
`ifdef PRIO_ENC_IDX_EN
      s1_lidx <= '0;
      s1_ridx <= '0;
`endif
    end else if (data_rdy_o) begin
      s1_vld <= data_val_i;
      if (data_val_i) begin
        s1_q <= '{nz: seg_nz, left: seg_left, right: seg_right};
`ifdef PRIO_ENC_IDX_EN
        s1_lidx <= seg_lidx;
        s1_ridx <= seg_ridx;
`endif
      end
    end
  end

  logic [WIDTH-1:0] left_n, right_n;

  // Highest non-empty segment wins for left, lowest for right; other segments stay zero.
  always_comb begin
    left_n  = '0;
    right_n = '0;
`ifdef PRIO_ENC_IDX_EN
    left_idx_n  = '0;
    right_idx_n = '0;
`endif
    for (int k = 0; k < NSEG; k++) begin
      if (s1_q.nz[k]) begin
        left_n                    = '0;
        left_n[k*SEG_W +: SEG_W]  = s1_q.left[k*SEG_W +: SEG_W];
`ifdef PRIO_ENC_IDX_EN
        left_idx_n = IW'(k * SEG_W + int'(s1_lidx[k*SIW +: SIW]));
`endif
      end
    end
    for (int k = NSEG - 1; k >= 0; k--) begin
      if (s1_q.nz[k]) begin
        right_n                   = '0;
        right_n[k*SEG_W +: SEG_W] = s1_q.right[k*SEG_W +: SEG_W];
`ifdef PRIO_ENC_IDX_EN
        right_idx_n = IW'(k * SEG_W + int'(s1_ridx[k*SIW +: SIW]));
`endif
      end
    end
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      data_val_o   <= 1'b0;
      data_left_o  <= '0;
      data_right_o <= '0;
      data_zero_o  <= 1'b0;
`ifdef PRIO_ENC_IDX_EN
      data_left_idx_o  <= '0;
      data_right_idx_o <= '0;
`endif
    end else if (rdy2) begin
      data_val_o <= s1_vld;
      if (s1_vld) begin
        data_left_o  <= left_n;
        data_right_o <= right_n;
        data_zero_o  <= ~|s1_q.nz;
`ifdef PRIO_ENC_IDX_EN
        data_left_idx_o  <= left_idx_n;
        data_right_idx_o <= right_idx_n;
`endif
      end
    end
  end

endmodule
